// File: rtl/fu_pkg.sv
// Shared opcodes, FSM states and latency classification for the functional unit.
package fu_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_SD  = 4'h2;
  localparam logic [3:0] OP_LD  = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  typedef enum logic {LAT_ALU, LAT_MEM} lat_class_t;

  // Loads and stores only compute an address; everything else, illegal ops included, is ALU class.
  function automatic lat_class_t lat_class(input logic [3:0] op);
    return (op == OP_SD || op == OP_LD) ? LAT_MEM : LAT_ALU;
  endfunction

endpackage

// File: rtl/func_unit_param_if.sv
// Issue and CDB handshake bundle between reservation station, functional unit and CDB arbiter.
interface func_unit_param_if #(
  parameter int DATA_W  = 16,
  parameter int TAG_W   = 8,
  parameter int INSTR_W = 16
);
  logic               issue_valid;
  logic               issue_ready;
  logic [INSTR_W-1:0] issue_instr;
  logic [TAG_W-1:0]   issue_tag;
  logic [DATA_W-1:0]  issue_r1;
  logic [DATA_W-1:0]  issue_r2;
  logic               cdb_valid;
  logic               cdb_grant;
  logic [DATA_W-1:0]  cdb_result;
  logic [TAG_W-1:0]   cdb_tag;
  logic [INSTR_W-1:0] cdb_instr;
  logic               cdb_illegal;
  logic               busy;

  modport master (
    output issue_valid, issue_instr, issue_tag, issue_r1, issue_r2, cdb_grant,
    input  issue_ready, cdb_valid, cdb_result, cdb_tag, cdb_instr, cdb_illegal, busy
  );

  modport slave (
    input  issue_valid, issue_instr, issue_tag, issue_r1, issue_r2, cdb_grant,
    output issue_ready, cdb_valid, cdb_result, cdb_tag, cdb_instr, cdb_illegal, busy
  );
endinterface

// File: rtl/fu_result_fifo.sv
// Synchronous result FIFO; head read combinationally from storage (zero while empty).
// Latency: a push is visible at the head on the next cycle when the FIFO was empty.
// Backpressure: push is dropped when full unless a pop happens on the same edge.
module fu_result_fifo #(
  parameter int W     = 41,
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CTW = $clog2(DEPTH + 1);

  logic [W-1:0]   mem [DEPTH];
  logic [PW-1:0]  wptr, rptr;
  logic [CTW-1:0] count;
  logic           do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CTW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rptr];

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wrap_inc(wptr);
      if (do_pop)  rptr <= wrap_inc(rptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CTW'(1);
        2'b01:   count <= count - CTW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clock) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/func_unit_param.sv
// Tomasulo functional unit: one instruction in flight, per-class latency, buffered CDB results.
// Latency: ALU_LAT/MEM_LAT edges from accept to buffer push; issue_ready returns the cycle after.
// Backpressure: full buffer parks the finished result in HOLD and keeps issue_ready low.
module func_unit_param
  import fu_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int TAG_W     = 8,
  parameter int INSTR_W   = 16,
  parameter int ALU_LAT   = 3,
  parameter int MEM_LAT   = 1,
  parameter int OUT_DEPTH = 2
) (
  input logic              clock,
  input logic              reset,
  func_unit_param_if.slave io
);
  localparam int ENT_W   = DATA_W + TAG_W + INSTR_W + 1;
  localparam int MAX_LAT = (ALU_LAT > MEM_LAT) ? ALU_LAT : MEM_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [DATA_W-1:0]  res_q;
  logic [TAG_W-1:0]   tag_q;
  logic [INSTR_W-1:0] instr_q;
  logic               ill_q;

  logic [3:0]         op;
  logic [DATA_W-1:0]  offs;
  logic [DATA_W-1:0]  alu_res;
  logic               alu_ill;
  logic               accept, pop, push, space, full, empty;
  logic [ENT_W-1:0]   head;

  assign op   = io.issue_instr[INSTR_W-1 -: 4];
  assign offs = DATA_W'(io.issue_instr[7:4]);

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (op)
      OP_ADD:         alu_res = io.issue_r2 + io.issue_r1;
      OP_SUB:         alu_res = io.issue_r2 - io.issue_r1;
      OP_SD, OP_LD:   alu_res = offs + io.issue_r2;
      OP_AND:         alu_res = io.issue_r1 & io.issue_r2;
      OP_OR:          alu_res = io.issue_r1 | io.issue_r2;
      default:        alu_ill = 1'b1;
    endcase
  end

  assign io.issue_ready = !reset && (state == IDLE);
  assign io.busy        = (state != IDLE);
  assign accept         = io.issue_valid && io.issue_ready;
  assign pop            = io.cdb_valid && io.cdb_grant;
  // A same-edge pop frees a slot, so a full buffer can still take the push.
  assign space          = !full || pop;

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = EXEC;
      EXEC: begin
        if (cnt == CW'(1)) begin
          if (space) begin
            push      = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (space) begin
          push      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      res_q   <= '0;
      tag_q   <= '0;
      instr_q <= '0;
      ill_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt     <= (lat_class(op) == LAT_MEM) ? CW'(MEM_LAT) : CW'(ALU_LAT);
        res_q   <= alu_res;
        tag_q   <= io.issue_tag;
        instr_q <= io.issue_instr;
        ill_q   <= alu_ill;
      end else if (state == EXEC && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  fu_result_fifo #(
    .W     (ENT_W),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .din   ({res_q, tag_q, instr_q, ill_q}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign io.cdb_valid = !empty;
  assign {io.cdb_result, io.cdb_tag, io.cdb_instr, io.cdb_illegal} = head;

endmodule

// File: doc/func_unit_param.md
Name: func_unit_param

Overview:
Parametrised next-generation functional unit for the Tomasulo core. It accepts one issued instruction at a time from a reservation station via a valid/ready handshake and executes it with a per-class latency (ALU vs. address calculation). It queues finished results in a small output buffer so a stalled common data bus (CDB) does not block completion. It sits between the reservation stations and the CDB arbiter.

Parameters:
DATA_W, 16, operand/result width
TAG_W, 8, instruction tag (instruction position) width
INSTR_W, 16, instruction word width; opcode = instr[INSTR_W-1 -: 4], offset = instr[7:4]
ALU_LAT, 3, cycles for ADD/SUB/AND/OR/illegal ops (>=1)
MEM_LAT, 1, cycles for LD/SD address calculation (>=1)
OUT_DEPTH, 2, result buffer entries (power of 2, >=1)

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high
issue_valid  in  1  reservation station presents an instruction
issue_ready  out  1  unit can accept this cycle
issue_instr  in  INSTR_W  instruction word
issue_tag  in  TAG_W  instruction position/tag
issue_r1  in  DATA_W  operand 1
issue_r2  in  DATA_W  operand 2
cdb_valid  out  1  result buffer head valid
cdb_grant  in  1  arbiter consumes head this cycle
cdb_result  out  DATA_W  head result
cdb_tag  out  TAG_W  head tag
cdb_instr  out  INSTR_W  head instruction word
cdb_illegal  out  1  head came from an unknown opcode
busy  out  1  execute slot occupied (EXEC or HOLD)

Behaviour:
- Reset (synchronous, active-high): state IDLE; cycle counter 0; buffer emptied; cdb_valid, cdb_result, cdb_tag, cdb_instr, cdb_illegal and busy all 0. issue_ready is 0 while reset is high. Reset mid-operation discards the in-flight instruction and all buffered results. Nothing is emitted on the CDB afterwards.
- issue_ready = !reset && state==IDLE. Accept = issue_valid && issue_ready.
- Opcodes and results, all modulo 2^DATA_W:
  - 0000 ADD: r2+r1
  - 0001 SUB: r2-r1
  - 0010 SD: zero-extended offset + r2
  - 0011 LD: zero-extended offset + r2
  - 0100 AND: r1&r2
  - 0101 OR: r1|r2
  - Any other opcode: result 0, illegal=1, ALU latency.
- The result, tag, instruction and illegal flag are computed and latched on the accept edge. Later changes on the issue_* inputs have no effect.
- States:
  - IDLE: on accept, counter:=LAT (ALU_LAT or MEM_LAT) and go to EXEC.
  - EXEC: counter decrements each edge. When counter==1 at an edge, push to the buffer if it is not full (counting a same-edge pop as freeing a slot) and go to IDLE. If the buffer is full, go to HOLD.
  - HOLD: push on the first edge where the buffer has space (including the same edge as a pop), then go to IDLE.
- Latency: an instruction accepted at edge k is pushed at edge k+LAT. cdb_valid rises after that edge if the buffer was empty. The next accept is possible at edge k+LAT+1 (issue_ready high in the cycle after the push).
- Buffer: FIFO order. Head is driven combinationally from storage. cdb_valid = !empty. Pop occurs when cdb_valid && cdb_grant. cdb_grant while empty is ignored. Pointers wrap modulo OUT_DEPTH.
- Simultaneous push and pop at full capacity is legal; occupancy stays unchanged.
- busy = state!=IDLE.

Decomposition:
- Package fu_pkg: opcode localparams (OP_ADD..OP_OR), state enum {IDLE, EXEC, HOLD}, and a function returning the latency class for an opcode.
- Sub-module fu_result_fifo: synchronous FIFO parametrised by width (DATA_W+TAG_W+INSTR_W+1) and OUT_DEPTH, with push/pop/full/empty outputs.
- The top level holds the FSM, counter and ALU.

Test Plan:
- Reset, then ADD r1=5 r2=7 tag=3 with cdb_grant=1 -> cdb_valid high exactly 3 edges after accept with result=12, tag=3, for one cycle; issue_ready low during EXEC.
- LD instr=0x3050, r2=0x0100 -> result 0x0105 visible 1 edge after accept. SUB r1=1 r2=0 -> 0xFFFF (wrap).
- cdb_grant=0, issue three ADDs (OUT_DEPTH=2) -> third enters HOLD with busy=1 and issue_ready=0. Grant one -> third is pushed on the same edge and results drain in tags order 1,2,3.
- Opcode 1111 -> result 0, cdb_illegal=1 after 3 cycles. Change issue_r1 after accept -> latched result unchanged.
- Assert reset during EXEC with one result buffered -> cdb_valid=0, busy=0 the next cycle, no stale result emitted after release; a new ADD completes normally.
